rfg_order_executor: RTL and testbench

Executes decoded host orders against the register file (RFG) bus in the FTDI host-link path. It sits between the order decoder, which produces header/address/length/value plus read/write strobes from the FTDI receive FIFO, and the FTDI transmit FIFO, which takes `rfg_read_done`/`rfg_read_data`. Register writes are forwarded directly to the RFG. Read orders are expanded into `length` single-byte RFG reads, with flow control and a per-read timeout.

---
 rtl/rfg_order_executor.sv | 209 ++++++++++++++++++++
 tb/tb_rfg_order_executor.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rfg_order_executor.sv
// Host-order executor: forwards register writes to the RFG bus and expands read
// orders into single-byte RFG reads pushed into the transmit FIFO.
module rfg_order_executor #(
  parameter int unsigned TIMEOUT      = 16,
  parameter logic [7:0]  TIMEOUT_FILL = 8'hEE,
  parameter int unsigned INC_BIT      = 0
) (
  input  logic        clk,
  input  logic        res_n,
  input  logic [7:0]  header,
  input  logic [7:0]  address,
  input  logic [15:0] length,
  input  logic [7:0]  value,
  input  logic        read,
  input  logic        write,
  output logic        busy,
  output logic [7:0]  rfg_address,
  output logic        rfg_write,
  output logic [7:0]  rfg_write_data,
  output logic        rfg_read,
  input  logic        rfg_read_valid,
  input  logic [7:0]  rfg_read_data_in,
  input  logic        wi_full,
  output logic        rfg_read_done,
  output logic [7:0]  rfg_read_data,
  input  logic        clear_err,
  output logic        timeout_err,
  output logic        order_err
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_ISSUE = 2'd1,
    ST_RD_WAIT  = 2'd2
  } state_t;

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 32'd1);
  localparam logic [2:0] INC_IDX    = 3'(INC_BIT);

  state_t state_r, state_next_s;

  logic [7:0]  cur_addr_r, cur_addr_s;
  logic [15:0] remaining_r, remaining_s;
  logic        inc_r, inc_s;
  logic [7:0]  timer_r, timer_s;
  logic        busy_r, busy_s;
  logic [7:0]  rfg_address_r, rfg_address_s;
  logic        rfg_write_r, rfg_write_s;
  logic [7:0]  rfg_write_data_r, rfg_write_data_s;
  logic        rfg_read_r, rfg_read_s;
  logic        rfg_read_done_r, rfg_read_done_s;
  logic [7:0]  rfg_read_data_r, rfg_read_data_s;
  logic        timeout_err_r, timeout_err_s;
  logic        order_err_r, order_err_s;

  logic idle_s, wr_go_s, rd_go_s, strobe_err_s;
  logic wait_s, got_valid_s, timed_out_s, push_s, last_s;
  logic unused_hdr_s;

  assign idle_s       = (state_r == ST_IDLE);
  assign wr_go_s      = idle_s & write;
  assign rd_go_s      = idle_s & read & ~write & (length != 16'd0);
  assign strobe_err_s = (read | write) & (~idle_s | (read & write));

  // Valid is only looked at once the cycle carrying rfg_read has passed.
  assign wait_s       = (state_r == ST_RD_WAIT) & ~rfg_read_r;
  assign got_valid_s  = wait_s & rfg_read_valid;
  assign timed_out_s  = wait_s & ~rfg_read_valid & (timer_r == TIMER_LAST);
  assign push_s       = got_valid_s | timed_out_s;
  assign last_s       = (remaining_r == 16'd1);
  assign unused_hdr_s = ^header;

  // State register.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (rd_go_s) state_next_s = ST_RD_ISSUE;
        else         state_next_s = ST_IDLE;
      end
      ST_RD_ISSUE: begin
        if (!wi_full) state_next_s = ST_RD_WAIT;
        else          state_next_s = ST_RD_ISSUE;
      end
      ST_RD_WAIT: begin
        if (push_s) state_next_s = last_s ? ST_IDLE : ST_RD_ISSUE;
        else        state_next_s = ST_RD_WAIT;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Next values for the registered outputs and the order datapath.
  always_comb begin
    cur_addr_s       = cur_addr_r;
    remaining_s      = remaining_r;
    inc_s            = inc_r;
    timer_s          = timer_r;
    rfg_address_s    = rfg_address_r;
    rfg_write_data_s = rfg_write_data_r;
    rfg_read_data_s  = rfg_read_data_r;
    rfg_write_s      = 1'b0;
    rfg_read_s       = 1'b0;
    rfg_read_done_s  = 1'b0;
    busy_s           = (state_next_s != ST_IDLE);

    // Set wins over a simultaneous clear.
    if (timed_out_s)    timeout_err_s = 1'b1;
    else if (clear_err) timeout_err_s = 1'b0;
    else                timeout_err_s = timeout_err_r;

    if (strobe_err_s)   order_err_s = 1'b1;
    else if (clear_err) order_err_s = 1'b0;
    else                order_err_s = order_err_r;

    case (state_r)
      ST_IDLE: begin
        if (wr_go_s) begin
          rfg_write_s      = 1'b1;
          rfg_address_s    = address;
          rfg_write_data_s = value;
        end else if (rd_go_s) begin
          cur_addr_s  = address;
          remaining_s = length;
          inc_s       = header[INC_IDX];
        end else begin
          timer_s = 8'd0;
        end
      end
      ST_RD_ISSUE: begin
        if (!wi_full) begin
          rfg_read_s    = 1'b1;
          rfg_address_s = cur_addr_r;
          timer_s       = 8'd0;
        end else begin
          rfg_read_s = 1'b0;
        end
      end
      ST_RD_WAIT: begin
        if (push_s) begin
          rfg_read_done_s = 1'b1;
          rfg_read_data_s = got_valid_s ? rfg_read_data_in : TIMEOUT_FILL;
          remaining_s     = remaining_r - 16'd1;
          cur_addr_s      = inc_r ? (cur_addr_r + 8'd1) : cur_addr_r;
        end else if (!rfg_read_r) begin
          timer_s = timer_r + 8'd1;
        end else begin
          timer_s = timer_r;
        end
      end
      default: begin
        timer_s = 8'd0;
      end
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      cur_addr_r       <= 8'd0;
      remaining_r      <= 16'd0;
      inc_r            <= 1'b0;
      timer_r          <= 8'd0;
      busy_r           <= 1'b0;
      rfg_address_r    <= 8'd0;
      rfg_write_r      <= 1'b0;
      rfg_write_data_r <= 8'd0;
      rfg_read_r       <= 1'b0;
      rfg_read_done_r  <= 1'b0;
      rfg_read_data_r  <= 8'd0;
      timeout_err_r    <= 1'b0;
      order_err_r      <= 1'b0;
    end else begin
      cur_addr_r       <= cur_addr_s;
      remaining_r      <= remaining_s;
      inc_r            <= inc_s;
      timer_r          <= timer_s;
      busy_r           <= busy_s;
      rfg_address_r    <= rfg_address_s;
      rfg_write_r      <= rfg_write_s;
      rfg_write_data_r <= rfg_write_data_s;
      rfg_read_r       <= rfg_read_s;
      rfg_read_done_r  <= rfg_read_done_s;
      rfg_read_data_r  <= rfg_read_data_s;
      timeout_err_r    <= timeout_err_s;
      order_err_r      <= order_err_s;
    end
  end

  assign busy           = busy_r;
  assign rfg_address    = rfg_address_r;
  assign rfg_write      = rfg_write_r;
  assign rfg_write_data = rfg_write_data_r;
  assign rfg_read       = rfg_read_r;
  assign rfg_read_done  = rfg_read_done_r;
  assign rfg_read_data  = rfg_read_data_r;
  assign timeout_err    = timeout_err_r;
  assign order_err      = order_err_r;

endmodule

// File: tb/tb_rfg_order_executor.sv
// Directed bench for rfg_order_executor: writes, incrementing/fixed reads,
// backpressure, timeout fill, protocol errors and reset mid-order.
module tb_rfg_order_executor;

  logic        clk = 1'b0;
  logic        res_n = 1'b0;
  logic [7:0]  header = 8'd0;
  logic [7:0]  address = 8'd0;
  logic [15:0] length = 16'd0;
  logic [7:0]  value = 8'd0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic        busy;
  logic [7:0]  rfg_address;
  logic        rfg_write;
  logic [7:0]  rfg_write_data;
  logic        rfg_read;
  logic        rfg_read_valid = 1'b0;
  logic [7:0]  rfg_read_data_in = 8'd0;
  logic        wi_full = 1'b0;
  logic        rfg_read_done;
  logic [7:0]  rfg_read_data;
  logic        clear_err = 1'b0;
  logic        timeout_err;
  logic        order_err;

  rfg_order_executor #(.TIMEOUT(16), .TIMEOUT_FILL(8'hEE), .INC_BIT(0)) dut (
    .clk(clk), .res_n(res_n), .header(header), .address(address), .length(length),
    .value(value), .read(read), .write(write), .busy(busy), .rfg_address(rfg_address),
    .rfg_write(rfg_write), .rfg_write_data(rfg_write_data), .rfg_read(rfg_read),
    .rfg_read_valid(rfg_read_valid), .rfg_read_data_in(rfg_read_data_in), .wi_full(wi_full),
    .rfg_read_done(rfg_read_done), .rfg_read_data(rfg_read_data), .clear_err(clear_err),
    .timeout_err(timeout_err), .order_err(order_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  int n_rd, n_done, n_wr, resp_idx, full_cnt, s;
  int rd_cyc [16];
  int done_cyc [16];
  logic [7:0] rd_addr [16];
  logic [7:0] done_data [16];
  logic [7:0] resp_q [8];
  logic resp_en = 1'b0;
  logic rd_prev = 1'b0;
  logic bp_arm = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs just after the edge, then drive next-cycle inputs.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    read = 1'b0;
    write = 1'b0;
    clear_err = 1'b0;
    if (rfg_read && n_rd < 16) begin
      rd_cyc[n_rd] = cyc;
      rd_addr[n_rd] = rfg_address;
      n_rd++;
    end
    if (rfg_read_done && n_done < 16) begin
      done_cyc[n_done] = cyc;
      done_data[n_done] = rfg_read_data;
      n_done++;
      if (bp_arm && n_done == 2) begin
        full_cnt = 10;
        bp_arm = 1'b0;
      end
    end
    if (rfg_write) n_wr++;
    if (resp_en && rd_prev && resp_idx < 8) begin
      rfg_read_valid = 1'b1;
      rfg_read_data_in = resp_q[resp_idx];
      resp_idx++;
    end else begin
      rfg_read_valid = 1'b0;
    end
    rd_prev = rfg_read;
    if (full_cnt > 0) begin
      wi_full = 1'b1;
      full_cnt--;
    end else begin
      wi_full = 1'b0;
    end
  endtask

  task automatic wait_idle(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      step();
      if (!busy) break;
    end
    check_eq("idle_reached", 32'(busy), 32'd0);
  endtask

  task automatic clear_log();
    n_rd = 0;
    n_done = 0;
    n_wr = 0;
    resp_idx = 0;
    full_cnt = 0;
  endtask

  function automatic logic [31:0] all_outs();
    return {2'b00, busy, rfg_write, rfg_read, rfg_read_done, timeout_err, order_err,
            rfg_address, rfg_write_data, rfg_read_data};
  endfunction

  initial begin
    clear_log();
    repeat (3) step();
    check_eq("reset_outs", all_outs(), 32'd0);
    res_n = 1'b1;
    step();

    // Single register write
    write = 1'b1; address = 8'h12; value = 8'hA5;
    step();
    check_eq("wr_strobe", 32'(rfg_write), 32'd1);
    check_eq("wr_addr", 32'(rfg_address), 32'h12);
    check_eq("wr_data", 32'(rfg_write_data), 32'hA5);
    check_eq("wr_busy", 32'(busy), 32'd0);
    step();
    check_eq("wr_pulse", 32'(rfg_write), 32'd0);

    // Incrementing read across the address wrap
    clear_log();
    resp_en = 1'b1;
    resp_q[0] = 8'h10; resp_q[1] = 8'h11; resp_q[2] = 8'h12;
    read = 1'b1; header = 8'h01; address = 8'hFE; length = 16'd3;
    s = cyc;
    step();
    check_eq("inc_busy", 32'(busy), 32'd1);
    wait_idle(100);
    check_eq("inc_busy_fall", 32'(cyc), 32'(done_cyc[2]));
    check_eq("inc_nrd", 32'(n_rd), 32'd3);
    check_eq("inc_ndone", 32'(n_done), 32'd3);
    check_eq("inc_first_rd", 32'(rd_cyc[0]), 32'(s + 2));
    check_eq("inc_a0", 32'(rd_addr[0]), 32'hFE);
    check_eq("inc_a1", 32'(rd_addr[1]), 32'hFF);
    check_eq("inc_a2", 32'(rd_addr[2]), 32'h00);
    check_eq("inc_d0", 32'(done_data[0]), 32'h10);
    check_eq("inc_d1", 32'(done_data[1]), 32'h11);
    check_eq("inc_d2", 32'(done_data[2]), 32'h12);
    check_eq("inc_lat", 32'(done_cyc[0] - rd_cyc[0]), 32'd2);
    check_eq("inc_gap1", 32'(done_cyc[1] - done_cyc[0]), 32'd3);
    check_eq("inc_gap2", 32'(done_cyc[2] - done_cyc[1]), 32'd3);

    // Fixed-address read with transmit FIFO backpressure
    clear_log();
    resp_q[0] = 8'h31; resp_q[1] = 8'h32; resp_q[2] = 8'h33; resp_q[3] = 8'h34;
    bp_arm = 1'b1;
    read = 1'b1; header = 8'h00; address = 8'h40; length = 16'd4;
    wait_idle(200);
    check_eq("fix_nrd", 32'(n_rd), 32'd4);
    check_eq("fix_ndone", 32'(n_done), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_eq("fix_addr", 32'(rd_addr[i]), 32'h40);
      check_eq("fix_data", 32'(done_data[i]), 32'(8'h31 + i));
    end
    check_eq("fix_bp_rd", 32'(rd_cyc[2] - done_cyc[1]), 32'd11);

    // Timeout fill
    clear_log();
    resp_en = 1'b0;
    read = 1'b1; header = 8'h01; address = 8'h20; length = 16'd2;
    wait_idle(200);
    check_eq("to_ndone", 32'(n_done), 32'd2);
    check_eq("to_d0", 32'(done_data[0]), 32'hEE);
    check_eq("to_d1", 32'(done_data[1]), 32'hEE);
    check_eq("to_lat0", 32'(done_cyc[0] - rd_cyc[0]), 32'd17);
    check_eq("to_lat1", 32'(done_cyc[1] - rd_cyc[1]), 32'd17);
    step(); step();
    check_eq("to_sticky", 32'(timeout_err), 32'd1);
    check_eq("to_no_order_err", 32'(order_err), 32'd0);
    clear_err = 1'b1;
    step();
    check_eq("to_cleared", 32'(timeout_err), 32'd0);

    // Protocol errors: write while busy, then read+write together
    clear_log();
    resp_en = 1'b1;
    resp_q[0] = 8'h01; resp_q[1] = 8'h02;
    read = 1'b1; header = 8'h00; address = 8'h50; length = 16'd2;
    step();
    write = 1'b1; address = 8'h77; value = 8'h99;
    step();
    check_eq("pe_busy_wr", 32'(rfg_write), 32'd0);
    check_eq("pe_order_err", 32'(order_err), 32'd1);
    wait_idle(100);
    check_eq("pe_nwr", 32'(n_wr), 32'd0);
    check_eq("pe_rd_addr", 32'(rd_addr[1]), 32'h50);
    clear_err = 1'b1;
    step();
    check_eq("pe_clr", 32'(order_err), 32'd0);
    clear_log();
    read = 1'b1; write = 1'b1; address = 8'h33; value = 8'h44; length = 16'd5;
    step();
    check_eq("pe_both_wr", 32'(rfg_write), 32'd1);
    check_eq("pe_both_addr", 32'(rfg_address), 32'h33);
    check_eq("pe_both_data", 32'(rfg_write_data), 32'h44);
    check_eq("pe_both_err", 32'(order_err), 32'd1);
    step(); step(); step();
    check_eq("pe_both_busy", 32'(busy), 32'd0);
    check_eq("pe_both_nrd", 32'(n_rd), 32'd0);

    // Reset during RD_WAIT, then late valid
    clear_log();
    resp_en = 1'b0;
    read = 1'b1; header = 8'h01; address = 8'h60; length = 16'd5;
    for (int i = 0; i < 10; i++) begin
      step();
      if (n_rd != 0) break;
    end
    check_eq("rm_issued", 32'(n_rd), 32'd1);
    step();
    res_n = 1'b0;
    #2;
    check_eq("rm_outs", all_outs(), 32'd0);
    step(); step();
    res_n = 1'b1;
    step();
    clear_log();
    rfg_read_valid = 1'b1; rfg_read_data_in = 8'h5A;
    step(); step();
    check_eq("rm_no_push", 32'(n_done), 32'd0);
    check_eq("rm_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
